// File: rtl/phase_sequencer.sv
// One-hot machine-cycle phase sequencer with memory stall, stall timeout, halt/resume and cycle counting.
// Define PHASE_SEQ_STEP_EN to compile in single-step support (step_mode/step_req).
module phase_sequencer #(
    parameter int NUM_PHASES = 3,
    parameter int MEM_PHASE  = 1,
    parameter int MAX_WAIT   = 15,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_wait,
    input  logic                  halt_req,
    input  logic                  resume,
    input  logic                  step_mode,
    input  logic                  step_req,
    output logic [NUM_PHASES-1:0] phase_oh,
    output logic                  cycle_done,
    output logic                  halted,
    output logic                  timeout_err,
    output logic [CNT_W-1:0]      cycle_count
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [7:0]            MAX_WAIT_C  = 8'(MAX_WAIT);
    localparam logic [NUM_PHASES-1:0] FIRST_PHASE = {{(NUM_PHASES-1){1'b0}}, 1'b1};

    state_t                state_r;
    state_t                state_nx_s;
    logic [NUM_PHASES-1:0] phase_r;
    logic [NUM_PHASES-1:0] phase_nx_s;
    logic [7:0]            stall_cnt_r;
    logic [7:0]            stall_nx_s;
    logic [CNT_W-1:0]      count_r;
    logic                  timeout_r;
    logic                  halted_r;
    logic                  timeout_set_s;
    logic                  advance_s;
    logic                  stop_s;
    logic                  start_s;

    // stop_s: leave the run loop at cycle end; start_s: begin a new cycle from HALT
`ifdef PHASE_SEQ_STEP_EN
    assign stop_s  = halt_req | step_mode;
    assign start_s = resume | (step_mode & step_req);
`else
    logic step_unused_s;
    assign stop_s        = halt_req;
    assign start_s       = resume;
    assign step_unused_s = step_mode | step_req;
`endif

    // Next-state, next-phase and stall-counter logic
    always_comb begin
        state_nx_s    = state_r;
        phase_nx_s    = phase_r;
        stall_nx_s    = stall_cnt_r;
        timeout_set_s = 1'b0;
        advance_s     = 1'b0;
        case (state_r)
            ST_START: begin
                state_nx_s = ST_RUN;
                phase_nx_s = FIRST_PHASE;
            end
            ST_RUN: begin
                if (phase_r[MEM_PHASE] && mem_wait) begin
                    state_nx_s = ST_STALL;
                    stall_nx_s = stall_cnt_r + 8'd1;
                end else begin
                    advance_s = 1'b1;
                end
            end
            ST_STALL: begin
                if (stall_cnt_r == MAX_WAIT_C) begin
                    advance_s     = 1'b1;
                    timeout_set_s = 1'b1;
                    stall_nx_s    = 8'd0;
                end else if (mem_wait) begin
                    stall_nx_s = stall_cnt_r + 8'd1;
                end else begin
                    advance_s  = 1'b1;
                    stall_nx_s = 8'd0;
                end
            end
            ST_HALT: begin
                if (start_s) begin
                    state_nx_s = ST_RUN;
                    phase_nx_s = FIRST_PHASE;
                end else begin
                    phase_nx_s = '0;
                end
            end
            default: begin
                state_nx_s = ST_START;
                phase_nx_s = '0;
                stall_nx_s = 8'd0;
            end
        endcase

        // Advancing out of the last phase ends the machine cycle
        if (advance_s) begin
            if (phase_r[NUM_PHASES-1]) begin
                if (stop_s) begin
                    state_nx_s = ST_HALT;
                    phase_nx_s = '0;
                end else begin
                    state_nx_s = ST_RUN;
                    phase_nx_s = FIRST_PHASE;
                end
            end else begin
                state_nx_s = ST_RUN;
                phase_nx_s = {phase_r[NUM_PHASES-2:0], phase_r[NUM_PHASES-1]};
            end
        end else begin
            phase_nx_s = phase_nx_s;
        end
    end

    // State, phase, flags and cycle counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_START;
            phase_r     <= '0;
            stall_cnt_r <= 8'd0;
            timeout_r   <= 1'b0;
            halted_r    <= 1'b0;
            count_r     <= '0;
        end else begin
            state_r     <= state_nx_s;
            phase_r     <= phase_nx_s;
            stall_cnt_r <= stall_nx_s;
            timeout_r   <= timeout_r | timeout_set_s;
            halted_r    <= (state_nx_s == ST_HALT);
            if (cycle_done) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // cycle_done marks the clock whose edge completes the cycle, so it cannot be registered
    assign cycle_done  = advance_s & phase_r[NUM_PHASES-1];
    assign phase_oh    = phase_r;
    assign halted      = halted_r;
    assign timeout_err = timeout_r;
    assign cycle_count = count_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (3 phases, stall on phase 1, MAX_WAIT 15, 4-bit counter).
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_wait;
    logic       halt_req;
    logic       resume;
    logic       step_mode;
    logic       step_req;
    logic [2:0] phase_oh;
    logic       cycle_done;
    logic       halted;
    logic       timeout_err;
    logic [3:0] cycle_count;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] cur_ph;
    logic [3:0] exp_cnt;
    logic       exp_to;

    phase_sequencer #(
        .NUM_PHASES(3),
        .MEM_PHASE (1),
        .MAX_WAIT  (15),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_wait   (mem_wait),
        .halt_req   (halt_req),
        .resume     (resume),
        .step_mode  (step_mode),
        .step_req   (step_req),
        .phase_oh   (phase_oh),
        .cycle_done (cycle_done),
        .halted     (halted),
        .timeout_err(timeout_err),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: check cycle_done before the edge, then phase/count/halted/timeout after it
    task automatic go(input string tag, input logic [2:0] ph);
        logic exp_done;
        #1;
        exp_done = (cur_ph == 3'b100) && (ph != 3'b100);
        check_val({tag, ".done"}, {31'd0, cycle_done}, {31'd0, exp_done});
        @(posedge clk);
        #1;
        if (exp_done) exp_cnt = exp_cnt + 4'd1;
        cur_ph = ph;
        check_val({tag, ".phase"}, {29'd0, phase_oh}, {29'd0, ph});
        check_val({tag, ".count"}, {28'd0, cycle_count}, {28'd0, exp_cnt});
        check_val({tag, ".halted"}, {31'd0, halted}, {31'd0, (ph == 3'b000)});
        check_val({tag, ".timeout"}, {31'd0, timeout_err}, {31'd0, exp_to});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".phase"}, {29'd0, phase_oh}, 32'd0);
        check_val({tag, ".done"}, {31'd0, cycle_done}, 32'd0);
        check_val({tag, ".halted"}, {31'd0, halted}, 32'd0);
        check_val({tag, ".timeout"}, {31'd0, timeout_err}, 32'd0);
        check_val({tag, ".count"}, {28'd0, cycle_count}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; mem_wait = 1'b0; halt_req = 1'b0; resume = 1'b0;
        step_mode = 1'b0; step_req = 1'b0;
        cur_ph = 3'b000; exp_cnt = 4'd0; exp_to = 1'b0;

        // Reset held for several edges
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        // Free run: 001,010,100 repeating
        go("run1", 3'b001); go("run2", 3'b010); go("run3", 3'b100);
        go("run4", 3'b001); go("run5", 3'b010); go("run6", 3'b100);
        go("run7", 3'b001); go("run8", 3'b010); go("run9", 3'b100);
        check_val("run.count2", {28'd0, cycle_count}, 32'd2);

        // Four-clock memory stall in phase 010
        go("pre", 3'b001); go("pre", 3'b010);
        mem_wait = 1'b1;
        for (int i = 0; i < 4; i++) go("stall4", 3'b010);
        mem_wait = 1'b0;
        go("stall4.out", 3'b100);
        go("stall4.next", 3'b001);

        // Stuck mem_wait forces an advance after 15 stall clocks
        go("to.pre", 3'b010);
        mem_wait = 1'b1;
        for (int i = 0; i < 15; i++) go("to.hold", 3'b010);
        exp_to = 1'b1;
        go("to.force", 3'b100);
        mem_wait = 1'b0;
        go("to.sticky", 3'b001);

        // halt_req pulsed in 010 is ignored, held through 100 halts
        go("h.a", 3'b010);
        halt_req = 1'b1;
        go("h.pulse", 3'b100);
        halt_req = 1'b0;
        go("h.ign", 3'b001);
        go("h.b", 3'b010);
        halt_req = 1'b1;
        go("h.c", 3'b100);
        go("h.halt", 3'b000);
        go("h.stay", 3'b000);
        resume = 1'b1;
        go("h.resume", 3'b001);
        resume = 1'b0;
        halt_req = 1'b0;

        // resume outside HALT changes nothing
        resume = 1'b1;
        go("r.ign", 3'b010);
        resume = 1'b0;
        go("r.c", 3'b100);
        go("r.d", 3'b001);

        // Enough cycles to wrap the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            go("wrap", 3'b010); go("wrap", 3'b100); go("wrap", 3'b001);
        end

        // Reset asserted mid-stall
        go("rs.pre", 3'b010);
        mem_wait = 1'b1;
        go("rs.stall", 3'b010);
        go("rs.stall", 3'b010);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rs.edge");
        @(posedge clk);
        #1;
        check_reset_outputs("rs.held");
        reset = 1'b0;
        mem_wait = 1'b0;
        cur_ph = 3'b000; exp_cnt = 4'd0; exp_to = 1'b0;
        go("rs.rel", 3'b001);

`ifdef PHASE_SEQ_STEP_EN
        // Step mode: halt at cycle end, each step_req runs exactly one cycle
        step_mode = 1'b1;
        go("st.a", 3'b010); go("st.b", 3'b100); go("st.halt", 3'b000);
        for (int k = 0; k < 3; k++) begin
            step_req = 1'b1;
            go("st.go", 3'b001);
            step_req = 1'b0;
            go("st.p1", 3'b010); go("st.p2", 3'b100); go("st.h", 3'b000);
        end
        check_val("st.count", {28'd0, cycle_count}, 32'd4);
        step_mode = 1'b0;
        resume = 1'b1;
        go("st.resume", 3'b001);
        resume = 1'b0;
        go("st.run", 3'b010);
`else
        // Step inputs have no effect when the feature is compiled out
        step_mode = 1'b1;
        step_req = 1'b1;
        go("ns.a", 3'b010); go("ns.b", 3'b100); go("ns.c", 3'b001);
        step_mode = 1'b0;
        step_req = 1'b0;
        check_val("ns.count", {28'd0, cycle_count}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
